// File: rtl/pipe_ctrl_gen.sv
// +--------------------------------------------------------------------------+
// | pipe_ctrl_gen: per-stage stall/flush resolution with deferred redirects |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl_gen #(
   parameter int NSTAGE = 6,
   parameter int CNT_W = 32,
   localparam int IDX_W = $clog2(NSTAGE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stall_req,
   input  logic [NSTAGE-1:0] flush_req,
   input  logic              hold_all,
   input  logic              cnt_clr,
   output logic [NSTAGE-1:0] stall_o,
   output logic [NSTAGE-1:0] flush_o,
   output logic              flush_pend,
   output logic [IDX_W-1:0]  flush_pend_idx,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [NSTAGE-1:0] C_STAGE0 = NSTAGE'(1);

   logic              pend_q, pend_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              es_acc;
   logic [NSTAGE-1:0] es, es_up, bubble, live, blocked, flush_w;
   logic              live_any, blk_any, pend_ok, act;
   logic [IDX_W-1:0]  live_hi, blk_hi, act_idx;
   logic              unused_flush0;

   assign unused_flush0 = flush_req[0];

   // es[k]: stage k is held by its own stall or any older one
   always_comb begin
      es_acc = hold_all;
      es     = '0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         es_acc = es_acc | stall_req[k];
         es[k]  = es_acc;
      end
   end

   // es_up[j] is the hold state of the stage just older than j
   assign es_up   = {1'b0, es[NSTAGE-1:1]};
   assign bubble  = {es[NSTAGE-2:0], 1'b0} & ~es & {NSTAGE{~hold_all}};
   assign live    = flush_req & ~es_up & {NSTAGE{~hold_all}} & ~C_STAGE0;
   assign blocked = flush_req & (es_up | {NSTAGE{hold_all}}) & ~C_STAGE0;
   assign pend_ok = pend_q & ~hold_all & ~es_up[idx_q];

   always_comb begin
      live_any = 1'b0;
      live_hi  = '0;
      blk_any  = 1'b0;
      blk_hi   = '0;
      for (int j = 1; j < NSTAGE; j++) begin
         if (live[j]) begin
            live_any = 1'b1;
            live_hi  = IDX_W'(j);
         end
         if (blocked[j]) begin
            blk_any = 1'b1;
            blk_hi  = IDX_W'(j);
         end
      end

      act     = live_any;
      act_idx = live_hi;
      if (pend_ok && (!live_any || idx_q > live_hi)) begin
         act     = 1'b1;
         act_idx = idx_q;
      end

      flush_w = bubble;
      for (int k = 0; k < NSTAGE; k++) begin
         if (act && (IDX_W'(k) < act_idx)) begin
            flush_w[k] = 1'b1;
         end
      end

      // While in reset the whole pipe is filled with bubbles
      if (rst) begin
         flush_o = '1;
         stall_o = '0;
      end else begin
         flush_o = flush_w;
         stall_o = es & ~flush_w;
      end
   end

   // Younger-or-equal blocked requests are dropped: the pending flush kills them
   always_comb begin
      pend_d = pend_q;
      idx_d  = idx_q;
      if (blk_any && (!pend_q || blk_hi > idx_q)) begin
         pend_d = 1'b1;
         idx_d  = blk_hi;
      end else if (pend_ok || (live_any && live_hi > idx_q)) begin
         pend_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (stall_o[0] && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= 1'b0;
         idx_q  <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
      end
   end

   assign flush_pend     = pend_q;
   assign flush_pend_idx = idx_q;
   assign stall_cnt      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_gen.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_ctrl_gen: vector table, directed sequences and random vs model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_ctrl_gen;

   localparam int N  = 6;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  stall_req, flush_req;
   logic          hold_all, cnt_clr;
   logic [N-1:0]  stall_o, flush_o;
   logic          flush_pend;
   logic [2:0]    flush_pend_idx;
   logic [CW-1:0] stall_cnt;

   int n_err = 0;
   int n_chk = 0;

   // reference model state and next-state
   logic m_pend, n_pend;
   int   m_idx, n_idx, m_cnt, n_cnt;
   logic [N-1:0] e_st, e_fl;

   typedef struct {
      logic [N-1:0] st;
      logic [N-1:0] fr;
      logic         ho;
      logic [N-1:0] exp_st;
      logic [N-1:0] exp_fl;
   } vec_t;

   vec_t vecs[9];

   pipe_ctrl_gen #(.NSTAGE(N), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
      .hold_all(hold_all), .cnt_clr(cnt_clr), .stall_o(stall_o), .flush_o(flush_o),
      .flush_pend(flush_pend), .flush_pend_idx(flush_pend_idx), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model from the rules: hs = oldest stalled stage; stage k held iff k<=hs.
   // A redirect from j is live iff nothing older than j is held, i.e. j>=hs.
   task automatic model_eval();
      int hs, a, la, bh;
      logic pok;
      hs = -1;
      for (int j = 0; j < N; j++) if (stall_req[j]) hs = j;
      la = -1; bh = -1;
      for (int j = 1; j < N; j++) begin
         if (flush_req[j]) begin
            if (!hold_all && j >= hs) la = j;
            else bh = j;
         end
      end
      pok = m_pend && !hold_all && (m_idx >= hs);
      a = la;
      if (pok && m_idx > a) a = m_idx;
      e_fl = (a > 0) ? N'((1 << a) - 1) : '0;
      if (!hold_all && hs >= 0 && hs < N - 1) e_fl = e_fl | N'(1 << (hs + 1));
      if (hold_all) e_st = '1;
      else e_st = (hs >= 0) ? N'((1 << (hs + 1)) - 1) : '0;
      e_st = e_st & ~e_fl;
      if (rst) begin
         e_fl = '1;
         e_st = '0;
      end
      n_pend = m_pend;
      n_idx  = m_idx;
      if (bh >= 1 && (!m_pend || bh > m_idx)) begin
         n_pend = 1'b1;
         n_idx  = bh;
      end else if (pok || (m_pend && la > m_idx)) begin
         n_pend = 1'b0;
      end
      if (cnt_clr) n_cnt = 0;
      else if (e_st[0] && m_cnt < CMAX) n_cnt = m_cnt + 1;
      else n_cnt = m_cnt;
   endtask

   task automatic drive(input logic [N-1:0] st, input logic [N-1:0] fr,
                        input logic ho, input logic cl);
      stall_req = st;
      flush_req = fr;
      hold_all  = ho;
      cnt_clr   = cl;
      #2;
      model_eval();
      chk("stall_o", 32'(stall_o), 32'(e_st));
      chk("flush_o", 32'(flush_o), 32'(e_fl));
      chk("flush_pend", 32'(flush_pend), 32'(m_pend));
      if (m_pend) chk("flush_pend_idx", 32'(flush_pend_idx), 32'(m_idx));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
   endtask

   task automatic tick();
      @(posedge clk);
      m_pend = n_pend;
      m_idx  = n_idx;
      m_cnt  = n_cnt;
      #1;
   endtask

   task automatic model_reset();
      m_pend = 1'b0;
      m_idx  = 0;
      m_cnt  = 0;
   endtask

   initial begin
      vecs[0] = '{6'b000100, 6'b000000, 1'b0, 6'b000111, 6'b001000};
      vecs[1] = '{6'b000000, 6'b000100, 1'b0, 6'b000000, 6'b000011};
      vecs[2] = '{6'b000000, 6'b000000, 1'b0, 6'b000000, 6'b000000};
      vecs[3] = '{6'b000000, 6'b000000, 1'b1, 6'b111111, 6'b000000};
      vecs[4] = '{6'b100000, 6'b000000, 1'b0, 6'b111111, 6'b000000};
      vecs[5] = '{6'b000001, 6'b000000, 1'b0, 6'b000001, 6'b000010};
      vecs[6] = '{6'b000100, 6'b100000, 1'b0, 6'b000000, 6'b011111};
      vecs[7] = '{6'b001000, 6'b001000, 1'b0, 6'b001000, 6'b010111};
      vecs[8] = '{6'b000000, 6'b000001, 1'b0, 6'b000000, 6'b000000};

      rst = 1'b1;
      stall_req = '0; flush_req = '0; hold_all = 1'b0; cnt_clr = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_flush_o", 32'(flush_o), 32'h3f);
      chk("rst_stall_o", 32'(stall_o), 32'h0);
      chk("rst_pend", 32'(flush_pend), 32'h0);
      chk("rst_idx", 32'(flush_pend_idx), 32'h0);
      chk("rst_cnt", 32'(stall_cnt), 32'h0);
      rst = 1'b0;

      // vector table
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].st, vecs[i].fr, vecs[i].ho, 1'b0);
         chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].exp_st));
         chk($sformatf("vec%0d_flush", i), 32'(flush_o), 32'(vecs[i].exp_fl));
         chk($sformatf("vec%0d_pend", i), 32'(flush_pend), 32'h0);
         tick();
      end

      // deferred redirect from stage 2 while stage 4 stalls
      drive(6'b010000, 6'b000100, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(6'b010000, 6'b000000, 1'b0, 1'b0);
         chk("defer_pend", 32'(flush_pend), 32'h1);
         chk("defer_idx", 32'(flush_pend_idx), 32'h2);
         tick();
      end
      drive(6'b000000, 6'b000000, 1'b0, 1'b0);
      chk("defer_apply", 32'(flush_o), 32'h03);
      tick();
      drive(6'b000000, 6'b000000, 1'b0, 1'b0);
      chk("defer_clear", 32'(flush_pend), 32'h0);
      tick();

      // older blocked request replaces pending; younger one dropped
      drive(6'b100000, 6'b000100, 1'b0, 1'b0);
      tick();
      drive(6'b100000, 6'b010000, 1'b0, 1'b0);
      chk("upg_idx_before", 32'(flush_pend_idx), 32'h2);
      tick();
      drive(6'b100000, 6'b000010, 1'b0, 1'b0);
      chk("upg_idx4", 32'(flush_pend_idx), 32'h4);
      tick();
      drive(6'b000000, 6'b000000, 1'b0, 1'b0);
      chk("drop_idx4", 32'(flush_pend_idx), 32'h4);
      chk("apply4", 32'(flush_o), 32'h0f);
      tick();

      // hold_all, then reset with a redirect pending
      drive(6'b100000, 6'b000010, 1'b0, 1'b0);
      tick();
      drive(6'b000000, 6'b000000, 1'b1, 1'b0);
      chk("hold_stall", 32'(stall_o), 32'h3f);
      chk("hold_flush", 32'(flush_o), 32'h0);
      chk("hold_pend", 32'(flush_pend), 32'h1);
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_flush", 32'(flush_o), 32'h3f);
      chk("midrst_stall", 32'(stall_o), 32'h0);
      chk("midrst_pend", 32'(flush_pend), 32'h0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      drive(6'b000000, 6'b000000, 1'b0, 1'b0);
      chk("postrst_flush", 32'(flush_o), 32'h0);
      tick();

      // counter saturation and clear priority
      drive(6'b000000, 6'b000000, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(6'b000001, 6'b000000, 1'b0, 1'b0);
         tick();
      end
      chk("cnt_sat", 32'(stall_cnt), 32'd15);
      drive(6'b000001, 6'b000000, 1'b0, 1'b1);
      tick();
      chk("cnt_clr", 32'(stall_cnt), 32'd0);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] st, fr;
         st = '0; fr = '0;
         for (int j = 0; j < N; j++) begin
            st[j] = ($urandom_range(0, 9) == 0);
            fr[j] = ($urandom_range(0, 7) == 0);
         end
         drive(st, fr, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
